// File: rtl/culsans_exit_ctrl_if.sv
// culsans_exit_ctrl_if: single-cycle req/gnt memory port between the SoC and the exit controller.
//   req_i/we_i/addr_i/wdata_i/be_i : request from the bus master
//   gnt_o                           : request accepted (same cycle)
//   rvalid_o/rdata_o/err_o          : response, one cycle after grant
interface culsans_exit_ctrl_if #(
    parameter int AddrWidth = 12
);
    logic                 req_i;
    logic                 we_i;
    logic [AddrWidth-1:0] addr_i;
    logic [31:0]          wdata_i;
    logic [3:0]           be_i;
    logic                 gnt_o;
    logic                 rvalid_o;
    logic [31:0]          rdata_o;
    logic                 err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/culsans_exit_ctrl.sv
// culsans_exit_ctrl: memory-mapped end-of-test responder with sticky exit status, 64-bit cycle counter and optional watchdog.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   bus     : req/gnt slave port (culsans_exit_ctrl_if.slave)
//   exit_o  : {return code, done}, sticky until reset
// Optional feature macro: CULSANS_EXIT_WDOG_EN enables the WDOG_LIMIT register and hang watchdog.
// Register map (byte offsets): 0x00 EXIT, 0x08 CYCLE_LO, 0x0C CYCLE_HI, 0x10 WDOG_LIMIT, 0x14 SCRATCH.
module culsans_exit_ctrl #(
    parameter int          AddrWidth   = 12,
    parameter int unsigned DrainCycles = 16,
    parameter logic [30:0] WdogCode    = 31'h0000_DEAD
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    culsans_exit_ctrl_if.slave  bus,
    output logic [31:0]         exit_o
);
    localparam int          WW        = AddrWidth - 2;
    localparam logic [7:0]  DrainLoad = 8'(DrainCycles - 1);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    logic [WW-1:0] word;
    logic          sel_exit, sel_lo, sel_hi, sel_wdog, sel_scr, hit, wr, rd;
    logic [63:0]   cyc_q;
    logic [31:0]   shadow_q, exit_q, scr_q, rdata_q, rdata_d, exit_wdata;
    logic          rvalid_q, err_q, exit_set, wdog_fire;
    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [30:0]   code_q, code_d;

    assign word     = bus.addr_i[AddrWidth-1:2];
    assign sel_exit = word == WW'(0);
    assign sel_lo   = word == WW'(2);
    assign sel_hi   = word == WW'(3);
    assign sel_wdog = word == WW'(4);
    assign sel_scr  = word == WW'(5);
    assign hit      = sel_exit | sel_lo | sel_hi | sel_wdog | sel_scr;
    assign wr       = bus.req_i & bus.we_i;
    assign rd       = bus.req_i & ~bus.we_i;

    assign exit_wdata = merge(exit_q, bus.wdata_i, bus.be_i);
    assign exit_set   = wr & sel_exit & bus.be_i[0] & bus.wdata_i[0];

`ifdef CULSANS_EXIT_WDOG_EN
    logic [31:0] wdog_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wdog_q <= '0;
        else if (wr && sel_wdog) wdog_q <= merge(wdog_q, bus.wdata_i, bus.be_i);
    end
    assign wdog_fire = (wdog_q != '0) && (cyc_q[31:0] >= wdog_q);
`else
    logic [31:0] wdog_q;
    assign wdog_q    = '0;
    assign wdog_fire = 1'b0;
`endif

    // Writes to CYCLE_LO/HI fall through every write arm and are silently dropped.
    assign rdata_d = sel_exit ? exit_q :
                     sel_lo   ? cyc_q[31:0] :
                     sel_hi   ? shadow_q :
                     sel_wdog ? wdog_q :
                     sel_scr  ? scr_q : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_q    <= '0;
            shadow_q <= '0;
            exit_q   <= '0;
            scr_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            cyc_q    <= cyc_q + 64'd1;
            rvalid_q <= bus.req_i;
            err_q    <= bus.req_i & ~hit;
            rdata_q  <= rd ? rdata_d : '0;
            // Snapshot the upper half so a following CYCLE_HI read pairs with this CYCLE_LO.
            if (rd && sel_lo) shadow_q <= cyc_q[63:32];
            if (wr && sel_exit) exit_q <= exit_wdata;
            if (wr && sel_scr) scr_q <= merge(scr_q, bus.wdata_i, bus.be_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            cnt_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    // Drain counter is loaded with DrainCycles-1 so DONE is visible DrainCycles+1 cycles after the grant.
    // The code is only latched on leaving RUN, so the first exit source wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        case (state_q)
            RUN: begin
                if (exit_set) begin
                    state_d = DRAIN;
                    cnt_d   = DrainLoad;
                    code_d  = exit_wdata[31:1];
                end else if (wdog_fire) begin
                    state_d = DRAIN;
                    cnt_d   = DrainLoad;
                    code_d  = WdogCode;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) state_d = DONE;
                else cnt_d = cnt_q - 8'd1;
            end
            default: ;
        endcase
    end

    assign exit_o       = (state_q == DONE) ? {code_q, 1'b1} : '0;
    assign bus.gnt_o    = bus.req_i;
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.err_o    = err_q;
endmodule
